// File: rtl/nx_fifo_thresh.sv
// Single-clock show-ahead FIFO with arbitrary depth, programmable almost-full/almost-empty
// thresholds, full-with-read pass-through and a high-water-mark register.
module nx_fifo_thresh #(
  parameter int DEPTH            = 8,
  parameter int WIDTH            = 64,
  parameter bit DATA_RESET       = 1'b1,
  parameter bit UNDERFLOW_ASSERT = 1'b1,
  parameter bit OVERFLOW_ASSERT  = 1'b1,
  localparam int CW              = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wen,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  input  logic [CW-1:0]    aempty_thresh,
  input  logic [CW-1:0]    afull_thresh,
  output logic [CW-1:0]    used_slots,
  output logic [CW-1:0]    free_slots,
  output logic             underflow,
  output logic             overflow,
  output logic [CW-1:0]    hwm,
  input  logic             hwm_clr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rptr, wptr;
  logic [CW-1:0]    count, count_next;
  logic             rd_ok, wr_ok;

  // Pointers wrap at DEPTH-1 so any depth works, not just powers of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign used_slots   = count;
  assign free_slots   = CW'(DEPTH) - count;
  assign almost_empty = (count <= aempty_thresh);
  assign almost_full  = (count >= afull_thresh);
  assign rdata        = empty ? '0 : mem[rptr];

  // A full FIFO still takes a write when the same cycle pops the head.
  assign rd_ok = ~clear & ren & ~empty;
  assign wr_ok = ~clear & wen & (~full | ren);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_next = count;
    if (clear)              count_next = '0;
    else if (wr_ok & ~rd_ok) count_next = count + CW'(1);
    else if (rd_ok & ~wr_ok) count_next = count - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr      <= '0;
      wptr      <= '0;
      count     <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      hwm       <= '0;
    end else begin
      count     <= count_next;
      underflow <= ~clear & ren & empty;
      overflow  <= ~clear & wen & full & ~ren;
      hwm       <= (hwm_clr || count_next > hwm) ? count_next : hwm;
      if (clear) begin
        rptr <= '0;
        wptr <= '0;
      end else begin
        if (rd_ok) rptr <= ptr_inc(rptr);
        if (wr_ok) wptr <= ptr_inc(wptr);
      end
    end
  end

  // NOTE: storage is only reset when DATA_RESET asks for it; rdata is masked while empty anyway.
  generate
    if (DATA_RESET) begin : g_mem_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
          mem[wptr] <= wdata;
        end
      end
    end else begin : g_mem_norst
      always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= wdata;
      end
    end
  endgenerate

`ifndef SYNTHESIS
  generate
    if (UNDERFLOW_ASSERT) begin : g_uf_chk
      a_underflow : assert property (@(posedge clk) disable iff (rst) !(ren && empty && !clear))
        else $error("nx_fifo_thresh: read of empty FIFO");
    end
    if (OVERFLOW_ASSERT) begin : g_of_chk
      a_overflow : assert property (@(posedge clk) disable iff (rst) !(wen && full && !ren && !clear))
        else $error("nx_fifo_thresh: write dropped on full FIFO");
    end
  endgenerate
`endif

endmodule

// File: tb/tb_nx_fifo_thresh.sv
// Self-checking bench for nx_fifo_thresh: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_nx_fifo_thresh;

  localparam int DEPTH = 5;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst, clear, wen, ren, hwm_clr;
  logic [WIDTH-1:0] wdata, rdata;
  logic             empty, full, almost_empty, almost_full, underflow, overflow;
  logic [CW-1:0]    aempty_thresh, afull_thresh, used_slots, free_slots, hwm;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  int               hwm_m;
  bit               uf_m, of_m;

  nx_fifo_thresh #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .DATA_RESET(1'b1),
    .UNDERFLOW_ASSERT(1'b0), .OVERFLOW_ASSERT(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .aempty_thresh(aempty_thresh), .afull_thresh(afull_thresh),
    .used_slots(used_slots), .free_slots(free_slots), .underflow(underflow),
    .overflow(overflow), .hwm(hwm), .hwm_clr(hwm_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, expected completion)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string ph);
    int sz;
    sz = q.size();
    check({ph, ".empty"},        64'(empty),        64'(sz == 0));
    check({ph, ".full"},         64'(full),         64'(sz == DEPTH));
    check({ph, ".used"},         64'(used_slots),   64'(sz));
    check({ph, ".free"},         64'(free_slots),   64'(DEPTH - sz));
    check({ph, ".almost_empty"}, 64'(almost_empty), 64'(sz <= int'(aempty_thresh)));
    check({ph, ".almost_full"},  64'(almost_full),  64'(sz >= int'(afull_thresh)));
    check({ph, ".rdata"},        64'(rdata),        (sz > 0) ? 64'(q[0]) : 64'(0));
    check({ph, ".underflow"},    64'(underflow),    64'(uf_m));
    check({ph, ".overflow"},     64'(overflow),     64'(of_m));
    check({ph, ".hwm"},          64'(hwm),          64'(hwm_m));
  endtask

  task automatic model_reset();
    q.delete();
    hwm_m = 0;
    uf_m  = 1'b0;
    of_m  = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance the model, then sample after the edge.
  task automatic cycle(input string ph, input bit w, input logic [WIDTH-1:0] wd,
                       input bit r, input bit c, input bit hc);
    int sz;
    bit rd_ok, wr_ok;
    logic [WIDTH-1:0] dummy;
    wen = w; wdata = wd; ren = r; clear = c; hwm_clr = hc;
    sz    = q.size();
    rd_ok = r && sz > 0;
    wr_ok = w && (sz < DEPTH || r);
    uf_m  = !c && r && sz == 0;
    of_m  = !c && w && sz == DEPTH && !r;
    if (c) q.delete();
    else begin
      if (rd_ok) dummy = q.pop_front();
      if (wr_ok) q.push_back(wd);
    end
    if (hc || q.size() > hwm_m) hwm_m = q.size();
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0; clear = 1'b0; hwm_clr = 1'b0;
    check_all(ph);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; wen = 1'b0; ren = 1'b0; hwm_clr = 1'b0; wdata = '0;
    aempty_thresh = 3'd1; afull_thresh = 3'd4;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // 1: fill to full
    for (int i = 1; i <= DEPTH; i++) cycle("t1_fill", 1'b1, 8'(i * 8'h11), 1'b0, 1'b0, 1'b0);
    check("t1_full", 64'(full), 64'd1);
    check("t1_rdata", 64'(rdata), 64'h11);
    check("t1_hwm", 64'(hwm), 64'd5);

    // 2: full-with-read pass-through, then drain across the pointer wrap
    cycle("t2_pass", 1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
    check("t2_rdata", 64'(rdata), 64'h22);
    for (int i = 0; i < DEPTH; i++) cycle("t2_drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 3: overflow pulse, then underflow pulse
    for (int i = 0; i < DEPTH; i++) cycle("t3_fill", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    cycle("t3_ovf", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    check("t3_ovf_pulse", 64'(overflow), 64'd1);
    cycle("t3_ovf_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle("t3_drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle("t3_udf", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("t3_udf_pulse", 64'(underflow), 64'd1);
    cycle("t3_udf_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // 4: write+read on empty
    cycle("t4_wr_rd_empty", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    check("t4_rdata", 64'(rdata), 64'hA5);
    check("t4_udf", 64'(underflow), 64'd1);

    // 5: clear with a write pending, then hwm_clr
    cycle("t5_fill", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    cycle("t5_fill", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    cycle("t5_clear", 1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    check("t5_hwm_kept", 64'(hwm), 64'd5);
    cycle("t5_hwm_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t5_hwm_zero", 64'(hwm), 64'd0);

    // 6: asynchronous reset mid-burst
    cycle("t6_fill", 1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    cycle("t6_fill", 1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    model_reset();
    check_all("t6_async_rst");
    @(negedge clk);
    rst = 1'b0;
    cycle("t6_after", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    check("t6_rdata", 64'(rdata), 64'h3C);

    // Randomized traffic with alternating write-heavy / read-heavy phases
    for (int n = 0; n < 400; n++) begin
      int wp;
      bit w, r, c, hc;
      if (n % 25 == 0) begin
        aempty_thresh = 3'($urandom_range(0, 7));
        afull_thresh  = 3'($urandom_range(0, 7));
      end
      wp = ((n / 40) % 2 == 0) ? 75 : 30;
      w  = ($urandom_range(0, 99) < wp);
      r  = ($urandom_range(0, 99) < 100 - wp);
      c  = ($urandom_range(0, 99) < 2);
      hc = ($urandom_range(0, 99) < 3);
      cycle("rand", w, 8'($urandom), r, c, hc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
